// File: rtl/seq_det_pkg.sv
// Shared types and reset defaults for the programmable sequence detector.
// Default pattern is the legacy "110" Mealy detector configuration.
package seq_det_pkg;

    localparam int unsigned DEF_PATTERN = 'b110;
    localparam int unsigned DEF_LEN     = 3;

    typedef enum logic {
        MEALY = 1'b0,
        MOORE = 1'b1
    } out_mode_t;

endpackage

// File: rtl/seq_detector_param_sat_counter.sv
// Saturating up-counter with sticky saturation flag.
// Ports: clk, reset_n, inc_i, clr_i -> cnt_o (W bits), sat_o.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W-1:0] cnt_o,
    output logic         sat_o
);

    logic [W-1:0] cnt_q, cnt_d;
    logic         sat_q, sat_d;

    always_comb begin
        cnt_d = cnt_q;
        sat_d = sat_q;
        if (clr_i) begin
            // A clear that coincides with an increment counts that event.
            cnt_d = {{(W-1){1'b0}}, inc_i};
            sat_d = 1'b0;
        end else if (inc_i && !(&cnt_q)) begin
            cnt_d = cnt_q + W'(1);
            sat_d = &cnt_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
            sat_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            sat_q <= sat_d;
        end
    end

    assign cnt_o = cnt_q;
    assign sat_o = sat_q;

endmodule

// File: rtl/seq_detector_param.sv
// Programmable serial pattern detector with run-time length, overlap and
// Mealy/Moore timing; counts matches in a saturating counter.
// Ports: clk, reset_n, cfg_load/pattern/len/overlap/moore, bit_valid,
//   bit_in, cnt_clr -> match, match_cnt, cnt_sat.
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter  int PAT_W = 8,
    parameter  int CNT_W = 16,
    localparam int LEN_W = $clog2(PAT_W + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_overlap,
    input  logic             cfg_moore,
    input  logic             bit_valid,
    input  logic             bit_in,
    input  logic             cnt_clr,
    output logic             match,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cnt_sat
);

    logic [PAT_W-1:0] pat_q, pat_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             ovl_q, ovl_d;
    out_mode_t        mode_q, mode_d;
    logic [PAT_W-1:0] hist_q, hist_d;
    logic [LEN_W-1:0] fill_q, fill_d;
    logic             match_q, match_d;

    logic [PAT_W:0]   window;
    logic [PAT_W:0]   mask;
    logic             hit;

    // Newest bit joins the history on the right; the mask keeps only the
    // low len bits, so the top window bit never takes part in a compare.
    always_comb begin
        window = {hist_q, bit_in};
        mask   = '0;
        for (int i = 0; i <= PAT_W; i++) begin
            mask[i] = (i < int'(len_q));
        end
        hit = bit_valid && !cfg_load && (len_q != '0)
            && (fill_q >= len_q - LEN_W'(1))
            && (((window ^ {1'b0, pat_q}) & mask) == '0);
    end

    always_comb begin
        pat_d   = pat_q;
        len_d   = len_q;
        ovl_d   = ovl_q;
        mode_d  = mode_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        match_d = hit;
        if (cfg_load) begin
            pat_d   = cfg_pattern;
            len_d   = (cfg_len > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : cfg_len;
            ovl_d   = cfg_overlap;
            mode_d  = out_mode_t'(cfg_moore);
            hist_d  = '0;
            fill_d  = '0;
            match_d = 1'b0;
        end else if (bit_valid) begin
            hist_d = window[PAT_W-1:0];
            if (hit && !ovl_q) begin
                fill_d = '0;
            end else if (fill_q != LEN_W'(PAT_W)) begin
                fill_d = fill_q + LEN_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pat_q   <= PAT_W'(DEF_PATTERN);
            len_q   <= LEN_W'(DEF_LEN);
            ovl_q   <= 1'b1;
            mode_q  <= MEALY;
            hist_q  <= '0;
            fill_q  <= '0;
            match_q <= 1'b0;
        end else begin
            pat_q   <= pat_d;
            len_q   <= len_d;
            ovl_q   <= ovl_d;
            mode_q  <= mode_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            match_q <= match_d;
        end
    end

    assign match = (mode_q == MOORE) ? match_q : hit;

    sat_counter #(
        .W (CNT_W)
    ) u_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc_i   (hit),
        .clr_i   (cnt_clr),
        .cnt_o   (match_cnt),
        .sat_o   (cnt_sat)
    );

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param with a match scoreboard queue.
// Uses CNT_W=4 so counter saturation is reachable quickly.
module tb_seq_detector_param;

    localparam int PAT_W = 8;
    localparam int CNT_W = 4;
    localparam int LEN_W = $clog2(PAT_W + 1);

    logic             clk = 1'b0;
    logic             reset_n;
    logic             cfg_load;
    logic [PAT_W-1:0] cfg_pattern;
    logic [LEN_W-1:0] cfg_len;
    logic             cfg_overlap;
    logic             cfg_moore;
    logic             bit_valid;
    logic             bit_in;
    logic             cnt_clr;
    logic             match;
    logic [CNT_W-1:0] match_cnt;
    logic             cnt_sat;

    int    checks = 0;
    int    errors = 0;
    logic  exp_q[$];
    string tag_q[$];

    seq_detector_param #(
        .PAT_W (PAT_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .cfg_moore   (cfg_moore),
        .bit_valid   (bit_valid),
        .bit_in      (bit_in),
        .cnt_clr     (cnt_clr),
        .match       (match),
        .match_cnt   (match_cnt),
        .cnt_sat     (cnt_sat)
    );

    always #5 clk = ~clk;

    task automatic pop_check();
        logic  e;
        string t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        checks++;
        assert (match === e) else begin
            errors++;
            $error("FAIL %s match observed=%0b expected=%0b", t, match, e);
        end
    endtask

    task automatic drive(input logic ld, input logic clr, input logic v,
                         input logic b, input logic em, input string tag);
        @(negedge clk);
        cfg_load  = ld;
        cnt_clr   = clr;
        bit_valid = v;
        bit_in    = b;
        exp_q.push_back(em);
        tag_q.push_back(tag);
        #1;
        pop_check();
    endtask

    task automatic step(input logic v, input logic b, input logic em,
                        input string tag);
        drive(1'b0, 1'b0, v, b, em, tag);
    endtask

    task automatic load(input logic [PAT_W-1:0] p, input logic [LEN_W-1:0] l,
                        input logic ovl, input logic moore, input logic clr,
                        input logic v, input logic b, input string tag);
        cfg_pattern = p;
        cfg_len     = l;
        cfg_overlap = ovl;
        cfg_moore   = moore;
        drive(1'b1, clr, v, b, 1'b0, tag);
    endtask

    task automatic chk_cnt(input logic [CNT_W-1:0] ec, input logic es,
                           input string tag);
        checks++;
        assert (match_cnt === ec) else begin
            errors++;
            $error("FAIL %s match_cnt observed=%0d expected=%0d",
                   tag, match_cnt, ec);
        end
        checks++;
        assert (cnt_sat === es) else begin
            errors++;
            $error("FAIL %s cnt_sat observed=%0b expected=%0b",
                   tag, cnt_sat, es);
        end
    endtask

    task automatic stream(input logic [15:0] bits, input logic [15:0] ems,
                          input int n, input string tag);
        for (int i = n - 1; i >= 0; i--) begin
            step(1'b1, bits[i], ems[i], tag);
        end
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        reset_n   = 1'b0;
        cfg_load  = 1'b0;
        cnt_clr   = 1'b0;
        bit_valid = 1'b0;
        bit_in    = 1'b0;
        #1;
        exp_q.push_back(1'b0);
        tag_q.push_back(tag);
        pop_check();
        chk_cnt('0, 1'b0, tag);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n     = 1'b0;
        cfg_load    = 1'b0;
        cfg_pattern = '0;
        cfg_len     = '0;
        cfg_overlap = 1'b0;
        cfg_moore   = 1'b0;
        bit_valid   = 1'b0;
        bit_in      = 1'b0;
        cnt_clr     = 1'b0;
        do_reset("reset");

        // 1: default "110" Mealy, overlapping stream
        stream(16'b0110110, 16'b0001001, 7, "t1_mealy");
        step(1'b0, 1'b0, 1'b0, "t1_idle");
        chk_cnt(4'd2, 1'b0, "t1_cnt");

        // 2: 1010 overlap=1 then overlap=0
        load(8'b1010, 4'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "t2_load");
        stream(16'b101010, 16'b000101, 6, "t2_ovl1");
        step(1'b0, 1'b0, 1'b0, "t2_idle");
        chk_cnt(4'd2, 1'b0, "t2_cnt_ovl1");
        load(8'b1010, 4'd4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "t2_load0");
        stream(16'b101010, 16'b000100, 6, "t2_ovl0");
        step(1'b0, 1'b0, 1'b0, "t2_idle0");
        chk_cnt(4'd1, 1'b0, "t2_cnt_ovl0");

        // 3: Moore, gaps between bits
        load(8'b110, 4'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, "t3_load");
        step(1'b1, 1'b1, 1'b0, "t3_b1");
        step(1'b0, 1'b0, 1'b0, "t3_gap1");
        step(1'b1, 1'b1, 1'b0, "t3_b2");
        step(1'b0, 1'b0, 1'b0, "t3_gap2");
        step(1'b1, 1'b0, 1'b0, "t3_b3");
        step(1'b0, 1'b0, 1'b1, "t3_moore_hit");
        step(1'b0, 1'b0, 1'b0, "t3_moore_1wide");
        chk_cnt(4'd1, 1'b0, "t3_cnt");

        // 4: load with a valid bit discards it
        load(8'b110, 4'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "t4_load");
        stream(16'b11, 16'b00, 2, "t4_pre");
        load(8'b110, 4'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "t4_load_bit");
        stream(16'b110, 16'b001, 3, "t4_post");
        step(1'b0, 1'b0, 1'b0, "t4_idle");
        chk_cnt(4'd1, 1'b0, "t4_cnt");

        // 5: saturation with pattern "1" len 1
        load(8'b1, 4'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "t5_load");
        for (int i = 0; i < 14; i++) begin
            step(1'b1, 1'b1, 1'b1, "t5_hit");
        end
        step(1'b1, 1'b1, 1'b1, "t5_hit15");
        chk_cnt(4'd14, 1'b0, "t5_cnt14");
        step(1'b1, 1'b1, 1'b1, "t5_hit16");
        chk_cnt(4'd15, 1'b1, "t5_cnt15");
        step(1'b0, 1'b0, 1'b0, "t5_idle");
        chk_cnt(4'd15, 1'b1, "t5_sat_hold");
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, "t5_clr_hit");
        step(1'b0, 1'b0, 1'b0, "t5_idle2");
        chk_cnt(4'd1, 1'b0, "t5_clr_cnt");

        // 6: reset mid-pattern, len clamp, len 0
        load(8'b110, 4'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "t6_load");
        stream(16'b11, 16'b00, 2, "t6_pre");
        do_reset("t6_reset");
        step(1'b1, 1'b0, 1'b0, "t6_after_rst");
        stream(16'b110, 16'b001, 3, "t6_fresh");
        step(1'b0, 1'b0, 1'b0, "t6_idle");
        chk_cnt(4'd1, 1'b0, "t6_cnt");
        load(8'b10110011, 4'd15, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "t6_clamp");
        stream(16'b10110011, 16'b00000001, 8, "t6_len8");
        load(8'b110, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "t6_len0");
        stream(16'b110110, 16'b000000, 6, "t6_disabled");
        step(1'b0, 1'b0, 1'b0, "t6_idle2");
        chk_cnt(4'd0, 1'b0, "t6_len0_cnt");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
